// File: rtl/divider_5x3.sv
// divider_5x3: sequential restoring divider, 5-bit dividend by 3-bit divisor.
// One quotient bit per clock, MSB first; divide-by-zero short-circuits to DONE.
module divider_5x3 (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] dividend,
    input  logic [2:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [4:0] quotient,
    output logic [2:0] remainder,
    output logic       divByZero
);

    localparam int unsigned DVD_W = 5;
    localparam int unsigned DVS_W = 3;
    localparam int unsigned REM_W = DVS_W + 1;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DVD_W-1:0]   dvd_q;
    logic [DVD_W-1:0]   dvd_d;
    logic [DVS_W-1:0]   dvs_q;
    logic [DVS_W-1:0]   dvs_d;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   rem_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DVD_W-1:0]   qacc_q;
    logic [DVD_W-1:0]   qacc_d;
    logic [DVD_W-1:0]   quotient_d;
    logic [DVS_W-1:0]   remainder_d;
    logic               dbz_d;
    logic               busy_d;
    logic               done_d;
    logic [REM_W-1:0]   rem_shift;
    logic [REM_W-1:0]   dvs_ext;
    logic               rem_ge;

    // State and datapath registers; reset clears everything to zero
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            qacc_q    <= '0;
            quotient  <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            qacc_q    <= qacc_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
            divByZero <= dbz_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state, one restoring step per RUN cycle, result load on entry to DONE
    always_comb begin
        state_next  = state;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        qacc_d      = qacc_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        dbz_d       = divByZero;

        // Partial remainder stays below the divisor, so its top bit is always 0 before the shift
        rem_shift = {rem_q[REM_W-2:0], dvd_q[cnt_q]};
        dvs_ext   = {1'b0, dvs_q};
        rem_ge    = (rem_shift >= dvs_ext);

        case (state)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    if (divisor != '0) begin
                        state_next = RUN;
                        rem_d      = '0;
                        cnt_d      = CNT_W'(DVD_W - 1);
                        qacc_d     = '0;
                    end else begin
                        state_next  = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d  = rem_ge ? (rem_shift - dvs_ext) : rem_shift;
                qacc_d = {qacc_q[DVD_W-2:0], rem_ge};
                if (cnt_q == '0) begin
                    state_next  = DONE;
                    quotient_d  = {qacc_q[DVD_W-2:0], rem_ge};
                    remainder_d = rem_d[DVS_W-1:0];
                    dbz_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_d = (state_next != IDLE);
        done_d = (state_next == DONE);
    end

endmodule

// File: tb/tb_divider_5x3.sv
// tb_divider_5x3: randomized self-checking bench against an arithmetic reference model.
module tb_divider_5x3;

    logic       clock;
    logic       reset;
    logic       start;
    logic [4:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [2:0] remainder;
    logic       divByZero;

    int n_checks = 0;
    int n_fail   = 0;
    int last_q   = 0;
    int last_r   = 0;
    int last_z   = 0;

    divider_5x3 dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the design wedges
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one division from a negedge in IDLE; inputs are scrambled and start
    // is toggled randomly after acceptance, which the design must ignore.
    task automatic do_div(input int a, input int b);
        int eq, er, ez, elat, ebusy;
        int n, busy_cnt;
        if (b == 0) begin
            eq = 31; er = 0; ez = 1; elat = 0; ebusy = 1;
        end else begin
            eq = a / b; er = a % b; ez = 0; elat = 5; ebusy = 6;
        end
        start    = 1'b1;
        dividend = 5'(a);
        divisor  = 3'(b);
        @(posedge clock);
        @(negedge clock);
        n = 0;
        busy_cnt = 0;
        while (!done && n < 12) begin
            if (busy) busy_cnt++;
            check("hold_q_run", 32'(quotient), 32'(last_q));
            start    = 1'($urandom_range(0, 1));
            dividend = 5'($urandom);
            divisor  = 3'($urandom);
            @(negedge clock);
            n++;
        end
        if (busy) busy_cnt++;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(n), 32'(elat));
        check("busy_cycles", 32'(busy_cnt), 32'(ebusy));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("divbyzero", 32'(divByZero), 32'(ez));
        if (b != 0)
            check("identity", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
        last_q = eq; last_r = er; last_z = ez;
        start = 1'($urandom_range(0, 1));
        @(negedge clock);
        check("done_pulse_one", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("hold_q_idle", 32'(quotient), 32'(last_q));
        start = 1'b0;
    endtask

    // Sit in IDLE and confirm results are held
    task automatic idle_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check("idle_done", 32'(done), 32'd0);
            check("idle_q", 32'(quotient), 32'(last_q));
            check("idle_r", 32'(remainder), 32'(last_r));
            check("idle_z", 32'(divByZero), 32'(last_z));
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_z", 32'(divByZero), 32'd0);
        reset = 1'b0;

        // Directed cases, issued back-to-back
        do_div(23, 3);
        do_div(5, 6);
        do_div(31, 1);
        do_div(9, 0);
        do_div(23, 3);
        do_div(17, 4);
        idle_hold(3);
        do_div(0, 0);
        do_div(0, 7);
        do_div(31, 7);

        // Inverse of the 2x3 multiplier
        for (int m = 0; m < 4; m++) begin
            for (int q = 1; q < 8; q++) begin
                do_div(m * q, q);
                check("inverse_q", 32'(quotient), 32'(m));
            end
        end

        // Random operands, divisor zero included
        for (int i = 0; i < 40; i++) begin
            do_div(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle_hold(1);
        end

        // Reset during the third RUN cycle aborts with no done pulse
        start    = 1'b1;
        dividend = 5'd17;
        divisor  = 3'd4;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            start = 1'b0;
            check("abort_no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_z", 32'(divByZero), 32'd0);
        reset = 1'b0;
        last_q = 0; last_r = 0; last_z = 0;
        do_div(20, 5);
        idle_hold(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_5x3.md
DIVIDER_5X3 -- requirements
Module: divider_5x3

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed and are the inverse of the team's 2x3 multiplier array: a 5-bit dividend and a 3-bit divisor.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  5  unsigned dividend; sampled on the accepting edge only.
REQ-006 divisor  input  3  unsigned divisor; sampled on the accepting edge only.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-009 quotient  output  5  unsigned quotient, registered.
REQ-010 remainder  output  3  unsigned remainder, registered.
REQ-011 divByZero  output  1  registered; set when the completed operation had divisor 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch dividend and divisor at that edge (the accept edge, k).
- If divisor != 0: go to RUN, clear the 4-bit partial remainder, load the bit counter with 4.
- If divisor == 0: go directly to DONE.
REQ-014 RUN SHALL perform one restoring step per clock, MSB first, for exactly 5 edges (k+1 .. k+5):
- r = {r[2:0], next dividend bit}.
- If r >= {0, divisor}: r = r - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
REQ-015 The partial remainder SHALL be 4 bits wide internally; the comparison and subtraction SHALL be 4 bits wide with no truncation.
REQ-016 At edge k+5 the block SHALL move to DONE and load quotient, remainder (r[2:0]) and divByZero=0 in the same edge.
REQ-017 Divide-by-zero: on the accept edge the block SHALL load quotient=5'b11111, remainder=3'b000 and divByZero=1.
REQ-018 done SHALL be high only while in DONE, which lasts exactly one cycle.
- Normal latency: done is high in the cycle after edge k+5.
- Divide-by-zero latency: done is high in the cycle after edge k.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally; start during DONE SHALL be ignored.
REQ-020 start while in RUN SHALL be ignored; changes to dividend or divisor after the accept edge SHALL NOT affect the result.
REQ-021 quotient, remainder and divByZero SHALL change only on entry to DONE (or on reset) and SHALL hold their values otherwise, including through subsequent IDLE cycles.
REQ-022 For every nonzero divisor, the result SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor.
REQ-023 A back-to-back start asserted in the first IDLE cycle after DONE SHALL be accepted; the minimum issue interval is 7 cycles.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, quotient, remainder, divByZero, the partial remainder and the counter to 0.
REQ-025 reset SHALL take priority over start and over any in-progress RUN or DONE; the aborted operation SHALL produce no done pulse.
REQ-026 In the first cycle after reset deasserts, the block SHALL accept a start.

Verification
REQ-027 dividend=23, divisor=3, start for one cycle -> done exactly 5 cycles after the accept edge; quotient=7, remainder=2, divByZero=0.
REQ-028 dividend=5, divisor=6 -> quotient=0, remainder=5; separately dividend=31, divisor=1 -> quotient=31, remainder=0.
REQ-029 dividend=9, divisor=0 -> done 1 cycle after acceptance; quotient=31, remainder=0, divByZero=1; the next normal division clears divByZero.
REQ-030 Start 17/4, then re-assert start with dividend=2, divisor=1 during RUN -> the second request is ignored; result quotient=4, remainder=1; busy high for 6 cycles.
REQ-031 Assert reset at RUN cycle 3 -> no done pulse; all outputs are 0 on the next cycle; a subsequent 20/5 yields quotient=4, remainder=0.
REQ-032 Exhaustive inverse check: for all m in 0..3 and q in 1..7, dividend=m*q with divisor=q -> quotient=m, remainder=0, matching the 2x3 multiplier product.
